// File: rtl/branch_corr_gen_pkg.sv
// Shared definitions for the ID-stage branch correction generator.
// Holds the 104-bit correction-bus width, field offsets, fall-through
// offsets, the per-slot decode record type and the helpers that classify a
// slot, compute its redirect PC and pack its correction record.
package branch_corr_gen_pkg;

  localparam int CORR_W      = 104;

  // Correction-bus field offsets (LSB positions for multi-bit fields)
  localparam int F_VALID     = 0;
  localparam int F_TAKEN     = 1;
  localparam int F_PC_LSB    = 2;
  localparam int F_TGT_LSB   = 34;
  localparam int F_UNCOND    = 66;
  localparam int F_LINK      = 67;
  localparam int F_RET       = 68;
  localparam int F_PHT       = 69;
  localparam int F_BHT       = 70;
  localparam int F_FLUSH_V   = 71;
  localparam int F_FLUSH_LSB = 72;

  // Not-taken branch resumes after its delay slot; an aliased non-branch
  // simply resumes at the next instruction.
  localparam logic [31:0] DELAY_SLOT_OFF = 32'd8;
  localparam logic [31:0] ALIAS_OFF      = 32'd4;

  typedef logic [CORR_W-1:0] corr_rec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        br;
    logic        uncond;
    logic        link;
    logic        ret;
    logic        taken;
    logic [31:0] target;
    logic        pred_flag;
    logic        pht_flag;
    logic [31:0] pred_addr;
  } slot_t;

  typedef enum logic [1:0] {
    SC_NONE    = 2'd0,  // empty slot or correctly unpredicted non-branch
    SC_BR_OK   = 2'd1,  // branch predicted correctly
    SC_MISPRED = 2'd2,  // branch with wrong direction or target
    SC_ALIAS   = 2'd3   // BTB hit on a non-branch
  } slot_class_e;

  function automatic slot_class_e classify(input slot_t s);
    slot_class_e c;
    if (!s.valid) begin
      c = SC_NONE;
    end else if (s.br) begin
      if ((s.taken != s.pred_flag) || (s.taken && (s.target != s.pred_addr))) begin
        c = SC_MISPRED;
      end else begin
        c = SC_BR_OK;
      end
    end else if (s.pred_flag) begin
      c = SC_ALIAS;
    end else begin
      c = SC_NONE;
    end
    return c;
  endfunction

  function automatic logic [31:0] redirect_addr(input slot_t s);
    logic [31:0] a;
    if (s.br) begin
      if (s.taken) begin
        a = s.target;
      end else begin
        a = s.pc + DELAY_SLOT_OFF;
      end
    end else begin
      a = s.pc + ALIAS_OFF;
    end
    return a;
  endfunction

  // Branches produce a training record; anything else (only ever called for
  // an aliased slot) produces a BTB flush record.
  function automatic corr_rec_t make_record(input slot_t s);
    corr_rec_t r;
    r = {CORR_W{1'b0}};
    if (s.br) begin
      r[F_VALID]          = 1'b1;
      r[F_TAKEN]          = s.taken;
      r[F_PC_LSB +: 32]   = s.pc;
      r[F_TGT_LSB +: 32]  = s.target;
      r[F_UNCOND]         = s.uncond;
      r[F_LINK]           = s.link;
      r[F_RET]            = s.ret;
      r[F_PHT]            = s.pht_flag;
      r[F_BHT]            = 1'b0;
    end else begin
      r[F_FLUSH_V]         = 1'b1;
      r[F_FLUSH_LSB +: 32] = s.pc;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_corr_gen_if.sv
// ID bundle interface: bundle valid/ready handshake plus the two decoded
// instruction slots with the predictions they carried from IF.
//   master : decode side (drives in_valid_i, slot1_i, slot2_i)
//   slave  : branch_corr_gen (drives in_ready_o)
interface branch_corr_gen_if;
  import branch_corr_gen_pkg::*;

  logic  in_valid_i;
  logic  in_ready_o;
  slot_t slot1_i;
  slot_t slot2_i;

  modport master (output in_valid_i, output slot1_i, output slot2_i, input in_ready_o);
  modport slave  (input in_valid_i, input slot1_i, input slot2_i, output in_ready_o);
endinterface

// File: rtl/branch_corr_gen_corr_queue.sv
// corr_queue: circular correction-record FIFO with a registered head.
// Up to two pushes and one pop per cycle; the head pops every cycle while
// entries are stored. When storage is empty the first push bypasses
// straight into the head register so a record is visible one cycle after
// it is pushed. i_clear empties storage and zeroes the head.
// Ports:
//   clk, rst          clock, async active-high reset
//   i_clear           synchronous flush
//   i_push0/i_data0   first push (always the older record)
//   i_push1/i_data1   second push (only with i_push0)
//   o_head            registered head, zero when no record
//   o_count           entries held in storage (excluding the head)
module corr_queue #(
  parameter int QDEPTH = 4,
  parameter int W      = 104
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic                       i_push0,
  input  logic [W-1:0]               i_data0,
  input  logic                       i_push1,
  input  logic [W-1:0]               i_data1,
  output logic [W-1:0]               o_head,
  output logic [$clog2(QDEPTH):0]    o_count
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [W-1:0]  r_mem [QDEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_head;

  logic          w_pop;
  logic          w_st0_en;
  logic          w_st1_en;
  logic [W-1:0]  w_st0_data;
  logic [CW-1:0] w_n_st;

  // Decide which pushes land in storage: with no pop the first push feeds the head
  always_comb begin
    w_pop      = (r_count != {CW{1'b0}});
    w_st0_en   = 1'b0;
    w_st1_en   = 1'b0;
    w_st0_data = i_data0;
    if (w_pop) begin
      w_st0_en   = i_push0;
      w_st1_en   = i_push1;
      w_st0_data = i_data0;
    end else begin
      w_st0_en   = i_push1;
      w_st1_en   = 1'b0;
      w_st0_data = i_data1;
    end
    w_n_st = CW'(w_st0_en) + CW'(w_st1_en);
  end

  // Storage array write; no reset needed since count guards every read
  always_ff @(posedge clk) begin
    if (!i_clear && w_st0_en) r_mem[r_wr] <= w_st0_data;
    if (!i_clear && w_st1_en) r_mem[r_wr + PTR_ONE] <= i_data1;
  end

  // Pointers, occupancy and registered head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= {PW{1'b0}};
      r_wr    <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
      r_head  <= {W{1'b0}};
    end else if (i_clear) begin
      r_rd    <= {PW{1'b0}};
      r_wr    <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
      r_head  <= {W{1'b0}};
    end else begin
      r_wr    <= r_wr + PW'(w_n_st);
      r_count <= r_count - CW'(w_pop) + w_n_st;
      if (w_pop) begin
        r_head <= r_mem[r_rd];
        r_rd   <= r_rd + PTR_ONE;
      end else if (i_push0) begin
        r_head <= i_data0;
      end else begin
        r_head <= {W{1'b0}};
      end
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;
endmodule

// File: rtl/branch_corr_gen.sv
// branch_corr_gen: ID-stage branch resolution and correction generator.
// Resolves up to two decoded slots per cycle against their IF predictions,
// issues a one-cycle registered fetch redirect on a mispredict or BTB alias,
// and serialises training / BTB-flush records onto the 104-bit correction
// bus through corr_queue.
// Ports:
//   clk, rst             clock, async active-high reset
//   exception_flag_i     exception flush (drops bundle, clears queue)
//   id_bus               ID bundle handshake and slots (slave modport)
//   branch_flag_o        registered redirect pulse
//   branch_addr_o        redirect PC
//   corr_branch_bus_o    registered correction record
//   stat_branches_o      enqueued branch records (saturating)
//   stat_mispred_o       redirects issued (saturating)
// Optional feature: define BRANCH_CORR_STAT_EN to build the statistics
// counters; otherwise both stat outputs are tied to zero.
module branch_corr_gen
  import branch_corr_gen_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exception_flag_i,
  branch_corr_gen_if.slave     id_bus,
  output logic                 branch_flag_o,
  output logic [31:0]          branch_addr_o,
  output logic [CORR_W-1:0]    corr_branch_bus_o,
  output logic [31:0]          stat_branches_o,
  output logic [31:0]          stat_mispred_o
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(QDEPTH - 2);

  logic          r_branch_flag;
  logic [31:0]   r_branch_addr;
  logic [CW-1:0] w_count;
  logic          w_accept;
  slot_class_e   w_cls1;
  slot_class_e   w_cls2;
  logic          w_s1_redir;
  logic          w_s2_live;
  logic          w_s2_redir;
  logic          w_s1_rec;
  logic          w_s2_rec;
  logic          w_redirect;
  logic [31:0]   w_redirect_addr;
  logic          w_push0;
  logic          w_push1;
  corr_rec_t     w_push0_data;
  corr_rec_t     w_push1_data;

  assign id_bus.in_ready_o = (w_count <= READY_MAX);

  // The cycle after a redirect carries wrong-path instructions, so it is not accepted
  assign w_accept = id_bus.in_valid_i && id_bus.in_ready_o &&
                    !exception_flag_i && !r_branch_flag;

  // Slot classification; a redirecting slot 1 squashes slot 2 entirely
  always_comb begin
    w_cls1     = classify(id_bus.slot1_i);
    w_cls2     = classify(id_bus.slot2_i);
    w_s1_redir = (w_cls1 == SC_MISPRED) || (w_cls1 == SC_ALIAS);
    w_s2_live  = !w_s1_redir;
    w_s2_redir = w_s2_live && ((w_cls2 == SC_MISPRED) || (w_cls2 == SC_ALIAS));
    w_s1_rec   = (w_cls1 != SC_NONE);
    w_s2_rec   = w_s2_live && (w_cls2 != SC_NONE);
    w_redirect = w_accept && (w_s1_redir || w_s2_redir);
    if (w_s1_redir) begin
      w_redirect_addr = redirect_addr(id_bus.slot1_i);
    end else if (w_s2_redir) begin
      w_redirect_addr = redirect_addr(id_bus.slot2_i);
    end else begin
      w_redirect_addr = 32'd0;
    end
  end

  // Compact the surviving records so the older one is always push 0
  always_comb begin
    w_push0      = 1'b0;
    w_push1      = 1'b0;
    w_push0_data = make_record(id_bus.slot1_i);
    w_push1_data = make_record(id_bus.slot2_i);
    if (w_s1_rec) begin
      w_push0 = w_accept;
      w_push1 = w_accept && w_s2_rec;
    end else if (w_s2_rec) begin
      w_push0      = w_accept;
      w_push0_data = make_record(id_bus.slot2_i);
    end else begin
      w_push0 = 1'b0;
    end
  end

  // Registered redirect; the address holds its last value between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_flag <= 1'b0;
      r_branch_addr <= 32'd0;
    end else begin
      r_branch_flag <= w_redirect;
      if (w_redirect) r_branch_addr <= w_redirect_addr;
    end
  end

  assign branch_flag_o = r_branch_flag;
  assign branch_addr_o = r_branch_addr;

  corr_queue #(
    .QDEPTH (QDEPTH),
    .W      (CORR_W)
  ) u_corr_queue (
    .clk     (clk),
    .rst     (rst),
    .i_clear (exception_flag_i || r_branch_flag),
    .i_push0 (w_push0),
    .i_data0 (w_push0_data),
    .i_push1 (w_push1),
    .i_data1 (w_push1_data),
    .o_head  (corr_branch_bus_o),
    .o_count (w_count)
  );

`ifdef BRANCH_CORR_STAT_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mis;
  logic [1:0]  w_br_cnt;
  logic [32:0] w_br_sum;

  // Branch records enqueued this cycle (0..2)
  always_comb begin
    if (w_accept) begin
      w_br_cnt = {1'b0, (w_cls1 == SC_BR_OK) || (w_cls1 == SC_MISPRED)} +
                 {1'b0, w_s2_live && ((w_cls2 == SC_BR_OK) || (w_cls2 == SC_MISPRED))};
    end else begin
      w_br_cnt = 2'd0;
    end
    w_br_sum = {1'b0, r_stat_br} + {31'd0, w_br_cnt};
  end

  // Saturating statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_br  <= 32'd0;
      r_stat_mis <= 32'd0;
    end else begin
      r_stat_br <= w_br_sum[32] ? 32'hFFFF_FFFF : w_br_sum[31:0];
      if (w_redirect && (r_stat_mis != 32'hFFFF_FFFF)) r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign stat_branches_o = r_stat_br;
  assign stat_mispred_o  = r_stat_mis;
`else
  assign stat_branches_o = 32'd0;
  assign stat_mispred_o  = 32'd0;
`endif

endmodule

// File: doc/branch_corr_gen.md
# branch_corr_gen

ID-stage branch resolution and correction generator: the producing end of the 104-bit correction bus consumed by the IF-stage predictor. Each cycle it takes up to two decoded instructions, with the predictions they carried from IF, and resolves their actual branch outcome. It issues a registered fetch redirect on a misprediction and serialises training and BTB-flush records into the correction bus through a 4-entry queue, one record per cycle.

## Interface
- Parameters: `QDEPTH`, default 4, queue depth (power of two, ≥2).
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `exception_flag_i` in 1: exception flush.
- `in_valid_i` in 1: ID bundle valid.
- `in_ready_o` out 1: accept; high when free entries ≥2.
- `slotN_valid_i` in 1 (N=1,2): slot holds an instruction.
- `slotN_pc_i` in 32.
- `slotN_br_i` in 1: decoded as branch/jump.
- `slotN_uncond_i`, `slotN_link_i`, `slotN_return_i` in 1: decoded kind.
- `slotN_taken_i` in 1: actual direction (1 for uncond).
- `slotN_target_i` in 32: actual target.
- `slotN_pred_flag_i` in 1: IF predicted taken.
- `slotN_pht_flag_i` in 1: raw PHT bit from IF.
- `slotN_pred_addr_i` in 32: IF predicted target.
- `branch_flag_o` out 1: redirect fetch (registered).
- `branch_addr_o` out 32: redirect PC.
- `corr_branch_bus_o` out 104: bit layout:
  - [0] valid
  - [1] taken
  - [33:2] inst addr
  - [65:34] target
  - [66] uncond
  - [67] link
  - [68] return
  - [69] pht flag
  - [70] bht flag (always 0)
  - [71] flush valid
  - [103:72] flush addr
- `stat_branches_o` out 32, `stat_mispred_o` out 32: counters (see Configuration).

## Operation
- A bundle is accepted when `in_valid_i && in_ready_o && !exception_flag_i && !branch_flag_o`. The bundle arriving in the cycle after a redirect is wrong-path and is dropped.
- Per-slot classification:
  - **Mispredict:** `br && (taken != pred_flag || taken && target != pred_addr)`. Redirect = taken ? target : pc+8 (delay slot).
  - **Alias:** `!br && pred_flag` (BTB hit on a non-branch). Redirect = pc+4.
- Slot 1 has priority. If slot 1 mispredicts or aliases, slot 2 is discarded entirely: no record, no redirect.
- Records enqueued, slot 1 before slot 2:
  - Branch → {valid=1, taken, pc, target, kind bits, pht_flag, flush=0}.
  - Alias → {valid=0, flush valid=1, flush addr=pc}, all other fields 0.
  - Non-branch, not aliased → no record.
- Queue: circular, `$clog2(QDEPTH)`-bit pointers with wrap, separate count. Simultaneous push of 0–2 entries and pop of 1 is supported. There is no backpressure from the predictor; the head pops every cycle while non-empty.
- `exception_flag_i` or `branch_flag_o` clears the queue at the next edge. Same-cycle enqueue is dropped when `exception_flag_i` is high. When only `branch_flag_o` is high, the incoming bundle is likewise dropped, as stated above.

## Timing
- Reset: queue empty, `corr_branch_bus_o`=0, `branch_flag_o`=0, `branch_addr_o`=0, counters=0.
- Redirect is a single-cycle pulse, one cycle after acceptance.
- A record appears on `corr_branch_bus_o` (registered head) at the earliest one cycle after acceptance. With two records, the second follows on the next cycle.
- `in_ready_o` is combinational from count: free ≥2.
- Reset asserted mid-operation empties the queue immediately (asynchronous).

## Configuration
- `BRANCH_CORR_STAT_EN` defined:
  - `stat_branches_o` increments per enqueued branch record (+2 when both slots).
  - `stat_mispred_o` increments per redirect.
  - Both saturate at 0xFFFF_FFFF.
- Undefined: both outputs tied to 0, counter logic absent.

## Structure
- `cpu.vh` holds:
  - correction-bus width (104);
  - field offset constants;
  - the delay-slot fall-through offset (8).
- One sub-module, `corr_queue`: parameterised 104-bit FIFO with 2-push / 1-pop ports and a clear input.
- Classification and redirect logic live in the top level.

## Test plan
- Slot 1 `beq` at 0x1000: taken, target 0x2000, pred_flag=0 → next cycle `branch_flag_o`=1, `branch_addr_o`=0x2000; then bus valid=1, taken=1, addr 0x1000, target 0x2000.
- Slot 1 `jal`, correctly predicted to 0x3000 (uncond, link); slot 2 `bne` not taken, pred 0 → no redirect; two records on consecutive cycles, the first with bits [66]=[67]=1.
- Slot 1 `addu` at 0x4000 with pred_flag=1 → redirect to 0x4004; bus bit71=1, flush addr 0x4000, bit0=0; slot 2 dropped.
- Hold `in_valid_i` with both slots branches while the queue fills → `in_ready_o` drops at count 3; no loss; records drain in order.
- `exception_flag_i` with 3 queued records → queue empty next cycle; `corr_branch_bus_o`=0 thereafter.
- Counters with macro defined: 5 branches, 2 mispredicts → `stat_branches_o`=5, `stat_mispred_o`=2; without the macro both read 0.
